// File: rtl/ddr2_responder.sv
`default_nettype none
// ============================================================================
//  Module   : ddr2_responder
//  Purpose  : Slave end of the stall-handshake memory bus. Backs requests with
//             an internal word array, adds a fixed access latency and inserts
//             periodic refresh windows to mimic DDR2 timing.
//  Revision : 1.0  initial release
// ============================================================================
module ddr2_responder #(
  parameter int ADDR_WIDTH     = 16,
  parameter int LATENCY        = 4,
  parameter int REFRESH_PERIOD = 1024,
  parameter int REFRESH_CYCLES = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ddr2_en,
  input  logic        ddr2_we,
  input  logic [31:0] ddr2_addr,
  input  logic [31:0] ddr2_wd,
  output logic        ddr2_stall,
  output logic [31:0] ddr2_rd,
  output logic        refreshing
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WAIT    = 2'd1;
  localparam logic [1:0] c_RESP    = 2'd2;
  localparam logic [1:0] c_REFRESH = 2'd3;

  localparam logic [31:0] c_LAT_LOAD = 32'(LATENCY - 1);
  localparam logic [31:0] c_REF_LOAD = 32'(REFRESH_CYCLES - 1);
  localparam int          c_DEPTH    = 1 << ADDR_WIDTH;

  logic [1:0]            r_state;
  logic [1:0]            w_next_state;
  logic [31:0]           r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wd;
  logic                  r_ref_pending;
  logic                  w_ref_tick;
  logic                  w_accept;
  logic                  w_ref_start;
  logic                  w_commit;
  logic [31:0]           r_mem [0:c_DEPTH-1];

  // A request is only taken from IDLE when no refresh is owed; refresh wins.
  assign w_accept    = (r_state == c_IDLE) & ~r_ref_pending & ddr2_en;
  assign w_ref_start = (r_state == c_IDLE) & r_ref_pending;
  // The WAIT->RESP edge is where the latched access actually touches memory.
  assign w_commit    = (r_state == c_WAIT) & (r_cnt == 32'd0);

  // Upper address bits are deliberately ignored, so the array aliases.
  generate
    if (ADDR_WIDTH < 32) begin : g_addr_alias
      logic w_unused_addr_bits;
      assign w_unused_addr_bits = &{1'b0, ddr2_addr[31:ADDR_WIDTH]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_IDLE: begin
        if (r_ref_pending) begin
          w_next_state = c_REFRESH;
        end else if (ddr2_en) begin
          w_next_state = c_WAIT;
        end
      end
      c_WAIT: begin
        if (r_cnt == 32'd0) begin
          w_next_state = c_RESP;
        end
      end
      c_RESP: begin
        w_next_state = c_IDLE;
      end
      c_REFRESH: begin
        if (r_cnt == 32'd0) begin
          w_next_state = c_IDLE;
        end
      end
      default: begin
        w_next_state = c_IDLE;
      end
    endcase
  end

  // Outputs: stall drops only in the completing cycle.
  always_comb begin
    ddr2_stall = ddr2_en & (r_state != c_RESP);
    refreshing = (r_state == c_REFRESH);
  end

  // Shared down-counter for access latency and refresh window length.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt <= 32'd0;
    end else if (w_accept) begin
      r_cnt <= c_LAT_LOAD;
    end else if (w_ref_start) begin
      r_cnt <= c_REF_LOAD;
    end else if (((r_state == c_WAIT) || (r_state == c_REFRESH)) && (r_cnt != 32'd0)) begin
      r_cnt <= r_cnt - 32'd1;
    end
  end

  // Capture the request on acceptance; later bus changes are ignored.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_wd   <= 32'd0;
    end else if (w_accept) begin
      r_we   <= ddr2_we;
      r_addr <= ddr2_addr[ADDR_WIDTH-1:0];
      r_wd   <= ddr2_wd;
    end
  end

  // Refresh timer: free-running, raises a tick once per period.
  generate
    if (REFRESH_PERIOD > 0) begin : g_refresh_on
      localparam int c_TW = (REFRESH_PERIOD > 1) ? $clog2(REFRESH_PERIOD) : 1;
      localparam logic [c_TW-1:0] c_REF_LAST = c_TW'(REFRESH_PERIOD - 1);
      logic [c_TW-1:0] r_ref_timer;

      // Count every cycle and wrap at the end of the period.
      always_ff @(posedge clock) begin
        if (reset) begin
          r_ref_timer <= '0;
        end else if (r_ref_timer == c_REF_LAST) begin
          r_ref_timer <= '0;
        end else begin
          r_ref_timer <= r_ref_timer + c_TW'(1);
        end
      end

      assign w_ref_tick = (r_ref_timer == c_REF_LAST);
    end else begin : g_refresh_off
      assign w_ref_tick = 1'b0;
    end
  endgenerate

  // Single pending flag: a tick while one is already owed is simply absorbed.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_ref_pending <= 1'b0;
    end else if (w_ref_tick) begin
      r_ref_pending <= 1'b1;
    end else if (w_ref_start) begin
      r_ref_pending <= 1'b0;
    end
  end

  // Array write port; contents survive reset, but an aborted write never lands.
  always_ff @(posedge clock) begin
    if (!reset && w_commit && r_we) begin
      r_mem[r_addr] <= r_wd;
    end
  end

  // Registered read port; holds its value between read completions.
  always_ff @(posedge clock) begin
    if (reset) begin
      ddr2_rd <= 32'd0;
    end else if (w_commit && !r_we) begin
      ddr2_rd <= r_mem[r_addr];
    end
  end

endmodule
`default_nettype wire

// File: doc/ddr2_responder.md
Name: ddr2_responder

Overview:
- Slave/responder end of the stall-handshake memory bus that the memory controller hub drives as a master (en/we/addr/wd out, stall/rd in).
- Backs the bus with an internal word-addressed array.
- Emulates DDR2 timing with a fixed access latency and periodic refresh windows.
- Used in simulation and as an on-chip stand-in for the external DDR2 bridge.

Parameters:
ADDR_WIDTH, 16, log2 of array depth in 32-bit words; ddr2_addr[ADDR_WIDTH-1:0] indexes the array, upper bits ignored (aliasing).
LATENCY, 4, wait cycles between request acceptance and response; legal range >= 1.
REFRESH_PERIOD, 1024, cycles between refresh requests; 0 disables refresh.
REFRESH_CYCLES, 8, length of one refresh window in cycles; legal range >= 1.

Ports:
clock  in  1  system clock; all state updates on its rising edge
reset  in  1  synchronous, active-high reset
ddr2_en  in  1  request valid; master holds it, with we/addr/wd stable, until a cycle with ddr2_stall=0
ddr2_we  in  1  1 = write, 0 = read
ddr2_addr  in  32  word address
ddr2_wd  in  32  write data
ddr2_stall  out  1  1 = request not complete; master must hold request
ddr2_rd  out  32  read data; valid in the completing cycle (en=1, stall=0) of a read
refreshing  out  1  high during refresh window (debug/LED)

Behaviour:
- Only one clock is used. Reset is synchronous and active-high.
- Reset state: state=IDLE, wait counter=0, refresh timer=0, refresh_pending=0, ddr2_rd=0, refreshing=0.
- Reset does not clear the memory array.
- ddr2_stall is combinational: stall = ddr2_en & (state != RESP). After reset it therefore follows ddr2_en.
- FSM states: IDLE, WAIT, RESP, REFRESH.
- IDLE:
  - If refresh_pending, go to REFRESH. Any en seen this cycle is not accepted, so stall=1.
  - Else if en, latch we/addr/wd and go to WAIT with counter=LATENCY-1. Stall=1.
  - Else stay in IDLE.
- WAIT: when counter==0, go to RESP; otherwise decrement the counter. Stall=1 throughout.
- Action on WAIT->RESP edge:
  - Latched write: commits mem[addr] <= wd.
  - Latched read: loads ddr2_rd <= mem[addr] (a registered array read; BRAM-inferable).
- RESP:
  - Stall=0. This is the completing cycle.
  - Go to IDLE unconditionally. There is no same-cycle re-accept.
- Timing:
  - Each transaction takes LATENCY+2 cycles from the first en cycle to the completing cycle inclusive.
  - Back-to-back requests therefore see stall=1 again in the cycle after RESP.
- ddr2_rd holds its last read value outside read completions. Writes do not change it.
- Refresh timer (REFRESH_PERIOD > 0):
  - The timer counts every cycle; on reaching REFRESH_PERIOD-1 it wraps to 0 and sets refresh_pending.
  - A pending refresh is taken only from IDLE. A refresh that falls due during WAIT/RESP is deferred until IDLE.
  - Timer ticks that fall due while refresh_pending is already set are dropped. A refresh is never queued twice.
- REFRESH:
  - Counter=REFRESH_CYCLES-1 on entry; decrements each cycle.
  - refreshing=1 and stall=en.
  - refresh_pending clears on entry.
  - At counter==0, return to IDLE. A waiting request is accepted in that IDLE cycle.
- Protocol violations:
  - Changes to we/addr/wd after acceptance are ignored; the latched values are used.
  - If en drops during WAIT, the transaction still completes internally (write committed, rd updated) and the FSM returns to IDLE.
- Reset mid-operation: the FSM aborts to IDLE. A write in WAIT that has not reached the RESP edge is not committed.

Test Plan:
- LATENCY=4, refresh disabled: write addr=0x10, wd=0xDEADBEEF, with en held. Stall is high for exactly 5 cycles, then low 1 cycle (6 cycles total). Then read addr=0x10: completing cycle shows rd=0xDEADBEEF, stall=0.
- Back-to-back: writes to 0x0..0x7 with data=addr*3, followed by reads of 0x0..0x7. Each read returns addr*3, and each transaction spans exactly 6 cycles.
- Aliasing, ADDR_WIDTH=16: write 0x1_0004 with 0x12345678, then read 0x0004. Returns 0x12345678.
- Refresh, REFRESH_PERIOD=32, REFRESH_CYCLES=8: issue continuous reads.
  - refreshing pulses high for 8 cycles, only starting from IDLE.
  - A request arriving during refresh completes 8+LATENCY+2 cycles later at most.
  - No data is corrupted.
- Deferred refresh: arrange for the timer to fall due mid-WAIT. Refresh starts in the cycle after RESP->IDLE and the in-flight read completes normally.
- Reset mid-write: assert reset during WAIT of a write of 0xCAFEF00D to 0x20 (prior contents 0x11111111). After reset, state is IDLE, rd=0, and reading 0x20 returns 0x11111111.
